// File: rtl/siren_pkg.sv
// Shared types and constants for the siren output stage.
package siren_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHIRP     = 3'd1,
        SOUND_ON  = 3'd2,
        SOUND_OFF = 3'd3,
        COOLDOWN  = 3'd4
    } state_t;

endpackage

// File: rtl/siren_ctrl_if.sv
// Siren stage signal bundle: alarm-side inputs, siren/LED outputs and a state debug view.
interface siren_ctrl_if;
    import siren_pkg::*;

    logic   alarm;
    logic   armed;
    logic   ignicao;
    logic   siren;
    logic   led;
    logic   busy;
    logic   timed_out;
    state_t state;

    modport master (
        output alarm, armed, ignicao,
        input  siren, led, busy, timed_out, state
    );

    modport slave (
        input  alarm, armed, ignicao,
        output siren, led, busy, timed_out, state
    );

endinterface

// File: rtl/siren_tick.sv
// Prescaler: one-cycle tick every PRESCALE clocks, held at zero while cleared.
module siren_tick
    import siren_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_presc;
    logic             w_tick;

    assign w_tick = !i_clear && (r_presc == LAST);
    assign o_tick = w_tick;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (i_clear || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + CNT_W'(1);
        end
    end

endmodule

// File: rtl/siren_ctrl.sv
// Siren output stage: beep pattern while alarmed, bounded episodes with cooldown,
// and a one-shot chirp on arming. Outputs are registered from the next-state decode.
module siren_ctrl
    import siren_pkg::*;
#(
    parameter int PRESCALE    = 4,
    parameter int ON_TICKS    = 2,
    parameter int OFF_TICKS   = 1,
    parameter int MAX_TICKS   = 6,
    parameter int COOL_TICKS  = 3,
    parameter int CHIRP_TICKS = 1
) (
    input  logic        clock,
    input  logic        reset,
    siren_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_TICKS - 1);
    localparam logic [CNT_W-1:0] CHIRP_LAST = CNT_W'(CHIRP_TICKS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_dur;
    logic             r_armed_q;
    logic             r_siren;
    logic             r_led;
    logic             r_busy;
    logic             r_timed_out;

    state_t           w_next;
    logic [CNT_W-1:0] w_phase_n;
    logic [CNT_W-1:0] w_dur_n;
    logic             w_tick;
    logic             w_start;
    logic             w_arm_edge;
    logic             w_siren_n;
    logic             w_led_n;
    logic             w_busy_n;
    logic             w_timed_out_n;

    // Prescaler is parked in IDLE so every episode times from its trigger.
    siren_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .i_clear (r_state == IDLE),
        .o_tick  (w_tick)
    );

    assign w_start    = bus.alarm && !bus.ignicao;
    assign w_arm_edge = bus.armed && !r_armed_q;

    always_comb begin
        w_next        = r_state;
        w_phase_n     = r_phase;
        w_dur_n       = r_dur;
        w_timed_out_n = 1'b0;
        if (w_tick) begin
            w_phase_n = r_phase + CNT_W'(1);
            w_dur_n   = r_dur + CNT_W'(1);
        end
        case (r_state)
            IDLE: begin
                w_phase_n = '0;
                w_dur_n   = '0;
                if (w_start)         w_next = SOUND_ON;
                else if (w_arm_edge) w_next = CHIRP;
            end
            CHIRP: begin
                if (w_start)                             w_next = SOUND_ON;
                else if (bus.ignicao)                    w_next = IDLE;
                else if (w_tick && r_phase == CHIRP_LAST) w_next = IDLE;
            end
            SOUND_ON, SOUND_OFF: begin
                if (bus.ignicao || !bus.alarm) begin
                    w_next = IDLE;
                end else if (w_tick && r_dur == MAX_LAST) begin
                    w_next        = COOLDOWN;
                    w_timed_out_n = 1'b1;
                end else if (w_tick && r_state == SOUND_ON && r_phase == ON_LAST) begin
                    w_next = SOUND_OFF;
                end else if (w_tick && r_state == SOUND_OFF && r_phase == OFF_LAST) begin
                    w_next = SOUND_ON;
                end
            end
            COOLDOWN: begin
                if (bus.ignicao)                         w_next = IDLE;
                else if (w_tick && r_phase == COOL_LAST) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_next != r_state) w_phase_n = '0;
        // Duration only carries across ON/OFF alternation within one episode.
        if (w_next == SOUND_ON && r_state != SOUND_ON && r_state != SOUND_OFF) w_dur_n = '0;
    end

    always_comb begin
        w_siren_n = (w_next == CHIRP) || (w_next == SOUND_ON);
        w_busy_n  = (w_next != IDLE);
        case (w_next)
            IDLE:      w_led_n = bus.armed;
            SOUND_OFF: w_led_n = 1'b0;
            default:   w_led_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_dur       <= '0;
            r_armed_q   <= 1'b1;
            r_siren     <= 1'b0;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_phase     <= w_phase_n;
            r_dur       <= w_dur_n;
            r_armed_q   <= bus.armed;
            r_siren     <= w_siren_n;
            r_led       <= w_led_n;
            r_busy      <= w_busy_n;
            r_timed_out <= w_timed_out_n;
        end
    end

    assign bus.siren     = r_siren;
    assign bus.led       = r_led;
    assign bus.busy      = r_busy;
    assign bus.timed_out = r_timed_out;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_siren_ctrl.sv
// Directed bench for siren_ctrl with default parameters; expected output
// vectors {siren, led, busy, timed_out} are queued per cycle and compared.
module tb_siren_ctrl;
    import siren_pkg::*;

    logic clock;
    logic reset;

    siren_ctrl_if bus ();

    siren_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {bus.siren, bus.led, bus.busy, bus.timed_out};
    endfunction

    // Standard 25-cycle episode: ON 8, OFF 4, ON 8, OFF 4, then timeout into cooldown.
    task automatic push_episode();
        for (int i = 1; i <= 24; i++) begin
            logic s;
            s = (i <= 8) || (i >= 13 && i <= 20);
            exp_q.push_back({s, s, 1'b1, 1'b0});
        end
        exp_q.push_back(4'b0111);
    endtask

    task automatic drain(input string tag);
        logic [3:0] e;
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            check(tag, 32'(outs()), 32'(e));
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.alarm   = 1'b0;
        bus.armed   = 1'b1;
        bus.ignicao = 1'b0;
        #2;
        check("reset_outs", 32'(outs()), 32'h0);
        check("reset_state", 32'(bus.state), 32'(IDLE));
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Armed already high out of reset: no chirp.
        for (int i = 0; i < 10; i++) begin
            step();
            check("armed_at_reset", 32'(outs()), 32'b0100);
        end

        // Arm edge chirp: four cycles of siren.
        bus.armed = 1'b0;
        step();
        step();
        check("disarmed_led", 32'(outs()), 32'b0000);
        bus.armed = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(4'b1110);
        exp_q.push_back(4'b0100);
        drain("chirp");

        // Held alarm: full episode, cooldown, idle, then fresh episode.
        bus.alarm = 1'b1;
        push_episode();
        for (int i = 0; i < 11; i++) exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1110);
        drain("episode");
        check("reentry_state", 32'(bus.state), 32'(SOUND_ON));
        bus.alarm = 1'b0;
        step();
        check("alarm_drop", 32'(outs()), 32'b0100);

        // Ignition abort in SOUND_ON.
        bus.alarm = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(4'b1110);
        drain("pre_ign");
        bus.ignicao = 1'b1;
        step();
        check("ign_abort", 32'(outs()), 32'b0100);
        for (int i = 0; i < 30; i++) begin
            step();
            check("ign_hold", 32'(outs()), 32'b0100);
        end
        bus.ignicao = 1'b0;
        bus.alarm   = 1'b0;
        step();

        // Alarm drop in SOUND_OFF, then re-assert: duration restarts.
        bus.alarm = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(4'b1110);
        for (int i = 0; i < 2; i++) exp_q.push_back(4'b0010);
        drain("pre_drop");
        bus.alarm = 1'b0;
        step();
        check("drop_off", 32'(outs()), 32'b0100);
        step();
        step();
        bus.alarm = 1'b1;
        push_episode();
        drain("restart");
        bus.alarm = 1'b0;
        for (int i = 0; i < 11; i++) exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0100);
        drain("cooldown_out");

        // Alarm during chirp: siren stays high, prescaler keeps running.
        bus.armed = 1'b0;
        step();
        step();
        bus.armed = 1'b1;
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b1110);
        drain("chirp_start");
        bus.alarm = 1'b1;
        step();
        check("chirp_to_on", 32'(bus.state), 32'(SOUND_ON));
        check("chirp_to_on_outs", 32'(outs()), 32'b1110);
        for (int i = 0; i < 5; i++) exp_q.push_back(4'b1110);
        exp_q.push_back(4'b0010);
        drain("chirp_handover");
        bus.alarm = 1'b0;
        step();
        check("chirp_exit", 32'(outs()), 32'b0100);

        // Asynchronous reset mid-episode.
        bus.alarm = 1'b1;
        step();
        step();
        check("pre_reset", 32'(outs()), 32'b1110);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'(outs()), 32'h0);
        check("async_reset_state", 32'(bus.state), 32'(IDLE));
        bus.alarm = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step();
        check("post_reset", 32'(outs()), 32'b0100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
